iob_timer_reader: RTL
=====================

IOB_TIMER_READER -- requirements
Module: iob_timer_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 4: IOb native master address width.
REQ-002 SHALL have parameter DATA_W, default 32: IOb data width; timestamp is 2*DATA_W.
REQ-003 SHALL have parameters RESET_ADDR=0, ENABLE_ADDR=1, SAMPLE_ADDR=2, DATA_LOW_ADDR=3, DATA_HIGH_ADDR=4: target timer register addresses.
REQ-004 SHALL have parameter TIMEOUT_W, default 8: bus wait-counter width.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port init_req  input  1  request timer init sequence.
REQ-008 SHALL have port sample_req  input  1  request timestamp capture.
REQ-009 SHALL have port busy  output  1  sequence in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err  output  1  one-cycle timeout pulse, coincident with done.
REQ-012 SHALL have port timestamp  output  2*DATA_W  last captured timer value.
REQ-013 SHALL have ports m_valid (output, 1), m_addr (output, ADDR_W), m_wdata (output, DATA_W), m_wstrb (output, DATA_W/8), m_rdata (input, DATA_W), m_ready (input, 1): IOb native master.

Function
REQ-014 States SHALL be IDLE, INIT_RST1, INIT_RST0, INIT_EN, SMP1, SMP0, RD_LO, RD_HI, GAP, FIN.
REQ-015 In IDLE, init_req=1 SHALL start INIT_RST1; else sample_req=1 SHALL start SMP1; both high: init wins, sample dropped (not queued).
REQ-016 Requests while busy SHALL be ignored; busy=1 in every state except IDLE.
REQ-017 Transactions: INIT_RST1 write RESET=1; INIT_RST0 write RESET=0; INIT_EN write ENABLE=1; SMP1 write SAMPLE=1; SMP0 write SAMPLE=0; RD_LO read DATA_LOW; RD_HI read DATA_HIGH.
REQ-018 Writes SHALL drive m_wstrb all-ones, m_wdata zero-extended value; reads SHALL drive m_wstrb=0, m_wdata=0.
REQ-019 m_valid, m_addr, m_wdata, m_wstrb SHALL be registered and held stable from assertion until the cycle m_ready=1 is sampled.
REQ-020 Transaction completes in the cycle m_valid=1 and m_ready=1; m_valid SHALL be low the next cycle (GAP), next transaction asserted the cycle after.
REQ-021 m_ready while m_valid=0 SHALL be ignored.
REQ-022 RD_LO SHALL latch m_rdata into a low holding register; RD_HI completion SHALL load timestamp={m_rdata, low holding} in one update.
REQ-023 Last transaction completion SHALL enter FIN: done=1 one cycle, then IDLE.
REQ-024 Zero-wait slave (m_ready same cycle as m_valid): done SHALL assert exactly 8 cycles after the sample accept cycle and 6 after the init accept cycle; each wait cycle adds one.
REQ-025 Wait counter SHALL clear at each m_valid assertion and increment each cycle m_valid=1, m_ready=0.
REQ-026 Counter reaching 2^TIMEOUT_W-1 with m_ready=0 SHALL abort: m_valid low next cycle, FIN with done=1, err=1, timestamp unchanged.
REQ-027 m_ready in the abort cycle SHALL be ignored; init sequence has no timestamp effect.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0, busy=0, done=0, err=0, timestamp=0, holding register=0, wait counter=0.
REQ-029 rst mid-sequence SHALL abandon it with no done/err pulse; first request after release SHALL start a fresh sequence.

Verification
REQ-030 Zero-wait slave, sample_req pulse, LOW=0x89ABCDEF, HIGH=0x01234567 -> writes SAMPLE 1 then 0, reads addr 3 then 4, done at +8 cycles, timestamp=0x0123456789ABCDEF, err=0.
REQ-031 init_req and sample_req same IDLE cycle -> write sequence addr 0 (1), 0 (0), 1 (1) only, done at +6, timestamp unchanged.
REQ-032 Slave stalls 3 cycles on RD_LO -> m_valid/m_addr stable 4 cycles, done at +11.
REQ-033 Slave never readies SMP0, TIMEOUT_W=4 -> abort after 15 wait cycles, done=err=1 one cycle, timestamp keeps prior value, late m_ready ignored.
REQ-034 rst asserted during RD_HI -> m_valid low same cycle, no done, timestamp=0; subsequent sample completes normally.
REQ-035 sample_req held high while busy -> exactly one sequence per IDLE visit, no queued extra.

Source files
------------

// File: rtl/iob_timer_reader_if.sv
// IOb native master/slave bus bundle used between the timer reader and the timer.
interface iob_timer_reader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic                  m_valid;
  logic [ADDR_W-1:0]     m_addr;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W/8-1:0]   m_wstrb;
  logic [DATA_W-1:0]     m_rdata;
  logic                  m_ready;

  modport master (output m_valid, m_addr, m_wdata, m_wstrb, input m_rdata, m_ready);
  modport slave  (input m_valid, m_addr, m_wdata, m_wstrb, output m_rdata, m_ready);
endinterface

// File: rtl/iob_timer_reader.sv
// Drives a timer peripheral over IOb: init sequence (reset pulse + enable) or
// sample sequence (sample pulse + 64-bit read), with per-transaction timeout.
module iob_timer_reader #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 32,
  parameter int RESET_ADDR     = 0,
  parameter int ENABLE_ADDR    = 1,
  parameter int SAMPLE_ADDR    = 2,
  parameter int DATA_LOW_ADDR  = 3,
  parameter int DATA_HIGH_ADDR = 4,
  parameter int TIMEOUT_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_req,
  input  logic                   sample_req,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [2*DATA_W-1:0]    timestamp,
  iob_timer_reader_if.master     m
);

  typedef enum logic [3:0] {
    IDLE, INIT_RST1, INIT_RST0, INIT_EN, SMP1, SMP0, RD_LO, RD_HI, GAP, FIN
  } state_t;

  state_t state, state_nxt, after_gap, after_gap_nxt;

  logic [TIMEOUT_W-1:0] wait_cnt;
  logic [DATA_W-1:0]    low_hold;
  logic                 xfer, timeout;
  logic                 nxt_valid;
  logic [ADDR_W-1:0]    nxt_addr;
  logic [DATA_W-1:0]    nxt_wdata;
  logic [DATA_W/8-1:0]  nxt_wstrb;

  // Transaction that follows a completed one; FIN marks the end of a sequence.
  function automatic state_t follow(input state_t s);
    case (s)
      INIT_RST1: follow = INIT_RST0;
      INIT_RST0: follow = INIT_EN;
      SMP1:      follow = SMP0;
      SMP0:      follow = RD_LO;
      RD_LO:     follow = RD_HI;
      default:   follow = FIN;
    endcase
  endfunction

  assign xfer    = m.m_valid && m.m_ready;
  // Abort wins over a late ready in the same cycle.
  assign timeout = m.m_valid && (wait_cnt == {TIMEOUT_W{1'b1}});

  always_comb begin
    state_nxt     = state;
    after_gap_nxt = after_gap;
    case (state)
      IDLE: begin
        if (init_req)        state_nxt = INIT_RST1;
        else if (sample_req) state_nxt = SMP1;
      end
      GAP:     state_nxt = after_gap;
      FIN:     state_nxt = IDLE;
      default: begin
        if (timeout) state_nxt = FIN;
        else if (xfer) begin
          if (follow(state) == FIN) state_nxt = FIN;
          else begin
            state_nxt     = GAP;
            after_gap_nxt = follow(state);
          end
        end
      end
    endcase
  end

  // Bus fields are decoded from the next state and registered, so they stay
  // stable for as long as the FSM waits in a transaction state.
  always_comb begin
    nxt_valid = 1'b1;
    nxt_addr  = '0;
    nxt_wdata = '0;
    nxt_wstrb = '0;
    case (state_nxt)
      INIT_RST1: begin nxt_addr = ADDR_W'(RESET_ADDR);  nxt_wdata = DATA_W'(1); nxt_wstrb = '1; end
      INIT_RST0: begin nxt_addr = ADDR_W'(RESET_ADDR);  nxt_wstrb = '1; end
      INIT_EN:   begin nxt_addr = ADDR_W'(ENABLE_ADDR); nxt_wdata = DATA_W'(1); nxt_wstrb = '1; end
      SMP1:      begin nxt_addr = ADDR_W'(SAMPLE_ADDR); nxt_wdata = DATA_W'(1); nxt_wstrb = '1; end
      SMP0:      begin nxt_addr = ADDR_W'(SAMPLE_ADDR); nxt_wstrb = '1; end
      RD_LO:     nxt_addr = ADDR_W'(DATA_LOW_ADDR);
      RD_HI:     nxt_addr = ADDR_W'(DATA_HIGH_ADDR);
      default:   nxt_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      after_gap <= IDLE;
      m.m_valid <= 1'b0;
      m.m_addr  <= '0;
      m.m_wdata <= '0;
      m.m_wstrb <= '0;
      wait_cnt  <= '0;
      low_hold  <= '0;
      timestamp <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      after_gap <= after_gap_nxt;
      m.m_valid <= nxt_valid;
      m.m_addr  <= nxt_addr;
      m.m_wdata <= nxt_wdata;
      m.m_wstrb <= nxt_wstrb;
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == FIN);
      err       <= timeout;
      if (state_nxt != state)            wait_cnt <= '0;
      else if (m.m_valid && !m.m_ready)  wait_cnt <= wait_cnt + TIMEOUT_W'(1);
      if (state == RD_LO && xfer && !timeout) low_hold  <= m.m_rdata;
      if (state == RD_HI && xfer && !timeout) timestamp <= {m.m_rdata, low_hold};
    end
  end

endmodule
